sram_rr_arbiter: RTL and testbench



---
 rtl/sram_arb_pkg.sv | 38 +++
 rtl/rr_arbiter.sv | 50 +++++
 rtl/sram_rr_arbiter.sv | 103 ++++++++++
 tb/tb_sram_rr_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and helpers for round-robin arbitration of a shared resource.
//   id_width(n) : requester index width, never below 1 bit.
//   rr_pick     : rotating-priority search, returns one-hot grant + index.
package sram_arb_pkg;

  localparam int unsigned MaxReq = 8;
  localparam int unsigned MaxIdW = 3;

  typedef struct packed {
    logic              found;
    logic [MaxIdW-1:0] idx;
    logic [MaxReq-1:0] gnt;
  } rr_pick_t;

  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Search upward from ptr, wrapping at n. ptr < n, so one subtraction wraps.
  function automatic rr_pick_t rr_pick(input logic [MaxReq-1:0] req,
                                       input logic [MaxIdW-1:0] ptr,
                                       input int unsigned       n);
    rr_pick_t    res;
    int unsigned cand;
    res = '0;
    for (int unsigned k = 0; k < MaxReq; k++) begin
      cand = int'(ptr) + k;
      if (cand >= n) cand = cand - n;
      if (!res.found && (k < n) && req[cand[MaxIdW-1:0]]) begin
        res.found                  = 1'b1;
        res.idx                    = cand[MaxIdW-1:0];
        res.gnt[cand[MaxIdW-1:0]]  = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with its own priority pointer.
//   clk, rst_n : clock, async active-low reset (pointer returns to 0)
//   req_i      : request vector
//   gnt_c      : one-hot grant (combinational, may depend on req_i)
//   gnt_id_c   : index of the granted requester
//   gnt_any_c  : some requester is granted
module rr_arbiter
  import sram_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 2,
  localparam int unsigned IdWidth = id_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_c,
  output logic [IdWidth-1:0] gnt_id_c,
  output logic               gnt_any_c
);

  localparam logic [IdWidth-1:0] LastId = IdWidth'(NUM_REQ - 1);

  rr_pick_t           pick;
  logic               unused_pick;
  logic [IdWidth-1:0] ptr_d;
  logic [IdWidth-1:0] ptr_q;

  // Grant selection
  always_comb begin
    pick        = rr_pick(MaxReq'(req_i), MaxIdW'(ptr_q), NUM_REQ);
    gnt_c       = pick.gnt[NUM_REQ-1:0];
    gnt_id_c    = pick.idx[IdWidth-1:0];
    gnt_any_c   = pick.found;
    unused_pick = ^pick;
  end

  // Pointer moves past the winner; explicit wrap for non-power-of-2 counts
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any_c) begin
      ptr_d = (gnt_id_c == LastId) ? '0 : gnt_id_c + IdWidth'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/sram_rr_arbiter.sv
// Shares one single-port SRAM (CEB/WEB/A/D/M/Q, 1-cycle read latency)
// among NUM_REQ requesters with round-robin priority.
//   CLK, RSTN                    : clock, async active-low reset
//   req_valid/req_ready          : per-requester handshake, ready is one-hot
//   req_we/addr/wdata/mask       : packed per-requester command slices
//   rsp_valid/rsp_id/rsp_data    : read response, one cycle after handshake
//   sram_ceb/web/a/d/m, sram_q   : SRAM macro pins
module sram_rr_arbiter
  import sram_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ      = 2,
  parameter  int unsigned WIDTH        = 128,
  parameter  int unsigned NUM_ROWS     = 4096,
  localparam int unsigned AddressWidth = $clog2(NUM_ROWS),
  localparam int unsigned IdWidth      = id_width(NUM_REQ)
) (
  input  logic                            CLK,
  input  logic                            RSTN,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0]              req_we,
  input  logic [NUM_REQ*AddressWidth-1:0] req_addr,
  input  logic [NUM_REQ*WIDTH-1:0]        req_wdata,
  input  logic [NUM_REQ*WIDTH-1:0]        req_mask,
  output logic                            rsp_valid,
  output logic [IdWidth-1:0]              rsp_id,
  output logic [WIDTH-1:0]                rsp_data,
  output logic                            sram_ceb,
  output logic                            sram_web,
  output logic [AddressWidth-1:0]         sram_a,
  output logic [WIDTH-1:0]                sram_d,
  output logic [WIDTH-1:0]                sram_m,
  input  logic [WIDTH-1:0]                sram_q
);

  logic [NUM_REQ-1:0] req_gated;
  logic [NUM_REQ-1:0] gnt;
  logic [IdWidth-1:0] gnt_id;
  logic               gnt_any;
  logic               we_sel;
  logic               rd_pend_d;
  logic               rd_pend_q;
  logic [IdWidth-1:0] rd_id_d;
  logic [IdWidth-1:0] rd_id_q;

  // Reset masks requests so no grant or SRAM enable escapes during reset
  assign req_gated = req_valid & {NUM_REQ{RSTN}};

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk       (CLK),
    .rst_n     (RSTN),
    .req_i     (req_gated),
    .gnt_c     (gnt),
    .gnt_id_c  (gnt_id),
    .gnt_any_c (gnt_any)
  );

  assign req_ready = gnt;

  // SRAM pins straight from the granted slice; idle drives inactive/zero
  always_comb begin
    sram_ceb = 1'b1;
    sram_web = 1'b1;
    sram_a   = '0;
    sram_d   = '0;
    sram_m   = '0;
    we_sel   = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sram_ceb = 1'b0;
        sram_web = ~req_we[i];
        sram_a   = req_addr[i*AddressWidth +: AddressWidth];
        sram_d   = req_wdata[i*WIDTH +: WIDTH];
        sram_m   = req_mask[i*WIDTH +: WIDTH];
        we_sel   = req_we[i];
      end
    end
  end

  // Track the owner of the read issued this cycle
  always_comb begin
    rd_pend_d = gnt_any & ~we_sel;
    rd_id_d   = rd_pend_d ? gnt_id : rd_id_q;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      rd_pend_q <= 1'b0;
      rd_id_q   <= '0;
    end else begin
      rd_pend_q <= rd_pend_d;
      rd_id_q   <= rd_id_d;
    end
  end

  // Q is already registered inside the macro, so data passes straight through
  assign rsp_valid = rd_pend_q;
  assign rsp_id    = rd_id_q;
  assign rsp_data  = sram_q;

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Directed bench for sram_rr_arbiter (3 requesters) with a behavioural SRAM.
module tb_sram_rr_arbiter;

  localparam int unsigned NR   = 3;
  localparam int unsigned W    = 32;
  localparam int unsigned ROWS = 1024;
  localparam int unsigned AW   = 10;
  localparam int unsigned IW   = 2;

  logic             clk = 1'b0;
  logic             rstn;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR-1:0]    req_we;
  logic [NR*AW-1:0] req_addr;
  logic [NR*W-1:0]  req_wdata;
  logic [NR*W-1:0]  req_mask;
  logic             rsp_valid;
  logic [IW-1:0]    rsp_id;
  logic [W-1:0]     rsp_data;
  logic             sram_ceb;
  logic             sram_web;
  logic [AW-1:0]    sram_a;
  logic [W-1:0]     sram_d;
  logic [W-1:0]     sram_m;
  logic [W-1:0]     sram_q;

  logic [W-1:0]     mem [ROWS];
  logic [W-1:0]     dat [NR];

  int n_tests = 0;
  int n_fail  = 0;

  sram_rr_arbiter #(
    .NUM_REQ  (NR),
    .WIDTH    (W),
    .NUM_ROWS (ROWS)
  ) dut (
    .CLK       (clk),
    .RSTN      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_mask  (req_mask),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .sram_ceb  (sram_ceb),
    .sram_web  (sram_web),
    .sram_a    (sram_a),
    .sram_d    (sram_d),
    .sram_m    (sram_m),
    .sram_q    (sram_q)
  );

  always #5 clk = ~clk;

  // Single-port SRAM: mask bit 1 keeps old data, reads registered
  always @(posedge clk) begin
    if (!sram_ceb) begin
      if (!sram_web) mem[sram_a] <= (mem[sram_a] & sram_m) | (sram_d & ~sram_m);
      else           sram_q      <= mem[sram_a];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drop();
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_mask  = '0;
  endtask

  task automatic put(input int i, input logic we, input logic [AW-1:0] a,
                     input logic [W-1:0] d, input logic [W-1:0] m);
    req_valid[i]        = 1'b1;
    req_we[i]           = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*W +: W]  = d;
    req_mask[i*W +: W]   = m;
  endtask

  task automatic chk_gnt(input string tag, input logic [NR-1:0] exp);
    chk({tag, "_ready"}, 64'(req_ready), 64'(exp));
    chk({tag, "_ceb"}, 64'(sram_ceb), 64'(exp == '0));
  endtask

  task automatic chk_rsp(input string tag, input logic v, input logic [IW-1:0] id,
                         input logic [W-1:0] d);
    chk({tag, "_rvalid"}, 64'(rsp_valid), 64'(v));
    if (v) begin
      chk({tag, "_rid"}, 64'(rsp_id), 64'(id));
      chk({tag, "_rdata"}, 64'(rsp_data), 64'(d));
    end
  endtask

  initial begin
    logic [NR-1:0] eg;
    int            g;
    int            pg;

    dat[0] = 32'hC0C0_0000;
    dat[1] = 32'hC1C1_1111;
    dat[2] = 32'hC2C2_2222;

    // Reset held 3 cycles, idle then with valids raised
    rstn = 1'b0;
    drop();
    cyc();
    for (int c = 0; c < 3; c++) begin
      if (c == 2) req_valid = '1;
      #2;
      chk_gnt("rst", '0);
      chk("rst_web", 64'(sram_web), 64'(1'b1));
      chk("rst_rvalid", 64'(rsp_valid), 64'(1'b0));
      chk("rst_rid", 64'(rsp_id), 64'(0));
      cyc();
    end
    drop();
    rstn = 1'b1;

    // Write then read through requester 0
    put(0, 1'b1, 10'h010, 32'hA5A5_A5A5, 32'h0);
    #2;
    chk_gnt("wr0", 3'b001);
    chk("wr0_web", 64'(sram_web), 64'(1'b0));
    chk("wr0_a", 64'(sram_a), 64'(10'h010));
    chk("wr0_d", 64'(sram_d), 64'(32'hA5A5_A5A5));
    chk("wr0_m", 64'(sram_m), 64'(32'h0));
    cyc();
    drop();
    put(0, 1'b0, 10'h010, 32'h0, 32'h0);
    #2;
    chk_gnt("rd0", 3'b001);
    chk("rd0_web", 64'(sram_web), 64'(1'b1));
    chk_rsp("after_wr", 1'b0, '0, '0);
    cyc();
    drop();
    #2;
    chk_gnt("idle0", '0);
    chk("idle0_web", 64'(sram_web), 64'(1'b1));
    chk("idle0_a", 64'(sram_a), 64'(0));
    chk_rsp("rd0_rsp", 1'b1, 2'd0, 32'hA5A5_A5A5);
    cyc();

    // Masked write through requester 1
    put(1, 1'b1, 10'h020, 32'hFFFF_FFFF, 32'h0);
    #2;
    chk_gnt("pre1", 3'b010);
    cyc();
    drop();
    put(1, 1'b1, 10'h020, 32'h0, 32'h0F0F_0F0F);
    #2;
    chk_gnt("mwr1", 3'b010);
    chk("mwr1_m", 64'(sram_m), 64'(32'h0F0F_0F0F));
    cyc();
    drop();
    put(1, 1'b0, 10'h020, 32'h0, 32'h0);
    #2;
    chk_gnt("mrd1", 3'b010);
    cyc();
    drop();
    #2;
    chk_rsp("mask_rsp", 1'b1, 2'd1, 32'h0F0F_0F0F);
    cyc();

    // Preload one word per requester; pointer ends at 0
    for (int i = 0; i < 3; i++) begin
      drop();
      put(i, 1'b1, AW'(10'h040 + i), dat[i], 32'h0);
      #2;
      eg = NR'(1 << i);
      chk_gnt("preload", eg);
      cyc();
    end

    // All three valid: strict 0,1,2,0,1,2 with matching responses
    drop();
    for (int i = 0; i < 3; i++) put(i, 1'b0, AW'(10'h040 + i), 32'h0, 32'h0);
    for (int c = 0; c < 6; c++) begin
      #2;
      g  = c % 3;
      pg = (c + 2) % 3;
      eg = NR'(1 << g);
      chk_gnt("rr", eg);
      chk("rr_a", 64'(sram_a), 64'(10'h040 + g));
      chk_rsp("rr", c > 0, IW'(pg), dat[pg]);
      cyc();
    end
    drop();
    #2;
    chk_gnt("rr_end", '0);
    chk_rsp("rr_last", 1'b1, 2'd2, dat[2]);
    cyc();

    // Move pointer to 2, then only 2 and 0 valid: 2,0,2,0
    put(1, 1'b0, 10'h041, 32'h0, 32'h0);
    #2;
    chk_gnt("mv1", 3'b010);
    cyc();
    drop();
    put(0, 1'b0, 10'h040, 32'h0, 32'h0);
    put(2, 1'b0, 10'h042, 32'h0, 32'h0);
    pg = 1;
    for (int c = 0; c < 4; c++) begin
      #2;
      g  = (c % 2 == 0) ? 2 : 0;
      eg = NR'(1 << g);
      chk_gnt("wrap", eg);
      chk_rsp("wrap", 1'b1, IW'(pg), dat[pg]);
      pg = g;
      cyc();
    end
    drop();
    #2;
    chk_rsp("wrap_last", 1'b1, 2'd0, dat[0]);
    cyc();

    // Lone requester continuously valid: granted every cycle
    put(1, 1'b0, 10'h041, 32'h0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      #2;
      chk_gnt("solo", 3'b010);
      chk_rsp("solo", c > 0, 2'd1, dat[1]);
      cyc();
    end
    drop();
    #2;
    chk_rsp("solo_last", 1'b1, 2'd1, dat[1]);
    cyc();

    // Write (req0) and read (req1) of the same address; read sees new data
    put(0, 1'b1, 10'h050, 32'hDEAD_BEEF, 32'h0);
    put(1, 1'b0, 10'h050, 32'h0, 32'h0);
    #2;
    chk_gnt("raw_wr", 3'b001);
    cyc();
    req_valid[0] = 1'b0;
    #2;
    chk_gnt("raw_rd", 3'b010);
    chk_rsp("raw_wr", 1'b0, '0, '0);
    cyc();
    drop();
    #2;
    chk_rsp("raw", 1'b1, 2'd1, 32'hDEAD_BEEF);
    cyc();

    // Reset right after a read handshake drops the response and the pointer
    put(1, 1'b0, 10'h041, 32'h0, 32'h0);
    #2;
    chk_gnt("mrst_rd", 3'b010);
    cyc();
    drop();
    rstn = 1'b0;
    #2;
    chk("mrst_rvalid", 64'(rsp_valid), 64'(1'b0));
    chk("mrst_ceb", 64'(sram_ceb), 64'(1'b1));
    cyc();
    cyc();
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) put(i, 1'b0, AW'(10'h040 + i), 32'h0, 32'h0);
    #2;
    chk_gnt("post_rst", 3'b001);
    chk("post_rst_rvalid", 64'(rsp_valid), 64'(1'b0));
    cyc();
    drop();
    #2;
    chk_rsp("post_rst", 1'b1, 2'd0, dat[0]);
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
